cdb_arbiter: RTL and testbench

Arbitrates the single common data bus (CDB) among the execution units: integer/ALU, load/AGU, multiplier and divider.
- Grants at most one requester per cycle.
- Registers the winner's result onto the CDB bundle consumed by the dispatch unit, tag FIFO, register status table and issue queues.
- Fixed priority favours long-latency units.
- An aging mechanism bounds how long any requester can starve.

---
 rtl/cdb_arbiter.sv | 114 +++++++++++
 tb/tb_cdb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one finished execution-unit result per cycle
// (starved requesters first, then fixed priority by index) and registers it onto the CDB.
module cdb_arbiter #(
  parameter int N_REQ        = 4,
  parameter int TAG_W        = 6,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*4-1:0]      req_flags,
  output logic [N_REQ-1:0]        grant,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic                    cdb_branch,
  output logic                    cdb_branch_taken,
  output logic                    cdb_jalr,
  output logic                    cdb_store_pc,
  output logic [N_REQ-1:0]        starved
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [N_REQ-1:0][7:0] age;
  logic [N_REQ-1:0][7:0] age_next;
  logic [N_REQ-1:0]      starve_req;
  logic [N_REQ-1:0]      pick;
  logic [N_REQ-1:0]      grant_raw;
  logic [TAG_W-1:0]      win_tag;
  logic [DATA_W-1:0]     win_data;
  logic [3:0]            win_flags;

  // starved mirrors age==LIMIT, so it can stand in for the age compare here
  always_comb begin
    starve_req = req & starved;
    pick       = (|starve_req) ? starve_req : req;
    grant_raw  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        grant_raw    = '0;
        grant_raw[i] = 1'b1;
      end
    end
    grant = rst ? grant_raw : '0;
  end

  always_comb begin
    win_tag   = '0;
    win_data  = '0;
    win_flags = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_tag   = req_tag[i*TAG_W +: TAG_W];
        win_data  = req_data[i*DATA_W +: DATA_W];
        win_flags = req_flags[i*4 +: 4];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && !grant[i]) begin
        age_next[i] = (age[i] == LIMIT) ? age[i] : age[i] + 8'd1;
      end else begin
        age_next[i] = 8'd0;
      end
    end
  end

  // tag/data hold when idle; flags are zeroed so an invalid cycle never looks like a branch
  always_ff @(posedge clk) begin
    if (!rst) begin
      cdb_valid        <= 1'b0;
      cdb_tag          <= '0;
      cdb_data         <= '0;
      cdb_branch       <= 1'b0;
      cdb_branch_taken <= 1'b0;
      cdb_jalr         <= 1'b0;
      cdb_store_pc     <= 1'b0;
    end else begin
      cdb_valid <= |grant;
      if (|grant) begin
        cdb_tag          <= win_tag;
        cdb_data         <= win_data;
        cdb_branch       <= win_flags[3];
        cdb_branch_taken <= win_flags[2];
        cdb_jalr         <= win_flags[1];
        cdb_store_pc     <= win_flags[0];
      end else begin
        cdb_branch       <= 1'b0;
        cdb_branch_taken <= 1'b0;
        cdb_jalr         <= 1'b0;
        cdb_store_pc     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      age     <= '0;
      starved <= '0;
    end else begin
      age <= age_next;
      for (int i = 0; i < N_REQ; i++) begin
        starved[i] <= (age_next[i] == LIMIT);
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized bench for cdb_arbiter, checked against a wait-count model.
module tb_cdb_arbiter;

  localparam int N     = 4;
  localparam int TW    = 6;
  localparam int DW    = 32;
  localparam int LIMIT = 3;
  localparam int BOUND = LIMIT + N - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [TW-1:0]   r_tag   [N];
  logic [DW-1:0]   r_data  [N];
  logic [3:0]      r_flags [N];
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N*4-1:0]  req_flags;
  logic [N-1:0]    grant;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic            cdb_branch, cdb_branch_taken, cdb_jalr, cdb_store_pc;
  logic [N-1:0]    starved;

  int tests = 0;
  int fails = 0;

  int            w [N];
  logic          exp_valid = 1'b0;
  logic [TW-1:0] exp_tag   = '0;
  logic [DW-1:0] exp_data  = '0;
  logic [3:0]    exp_flags = '0;
  int            last_g    = -1;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]   = r_tag[i];
      req_data[i*DW +: DW]  = r_data[i];
      req_flags[i*4 +: 4]   = r_flags[i];
    end
  end

  cdb_arbiter #(
    .N_REQ(N), .TAG_W(TW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_tag(req_tag), .req_data(req_data),
    .req_flags(req_flags), .grant(grant), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken),
    .cdb_jalr(cdb_jalr), .cdb_store_pc(cdb_store_pc), .starved(starved)
  );

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d,
                               input logic [3:0] f);
    req[i]     = 1'b1;
    r_tag[i]   = t;
    r_data[i]  = d;
    r_flags[i] = f;
  endtask

  // Age of a requester is just how many cycles it has been waiting, capped at LIMIT
  function automatic int modelPick();
    if (!rst) return -1;
    for (int i = 0; i < N; i++) if (req[i] && w[i] >= LIMIT) return i;
    for (int i = 0; i < N; i++) if (req[i]) return i;
    return -1;
  endfunction

  task automatic step();
    int g;
    logic [N-1:0] eg;
    logic [N-1:0] es;
    #1;
    g  = modelPick();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    for (int i = 0; i < N; i++) es[i] = (w[i] >= LIMIT);
    checkOutput("grant", 32'(grant), 32'(eg));
    checkOutput("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    checkOutput("cdb_valid", 32'(cdb_valid), 32'(exp_valid));
    checkOutput("cdb_tag", 32'(cdb_tag), 32'(exp_tag));
    checkOutput("cdb_data", cdb_data, exp_data);
    checkOutput("cdb_flags", 32'({cdb_branch, cdb_branch_taken, cdb_jalr, cdb_store_pc}),
                32'(exp_flags));
    checkOutput("starved", 32'(starved), 32'(es));
    for (int i = 0; i < N; i++) checkOutput("wait_bound", 32'(w[i] <= BOUND), 32'd1);
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < N; i++) w[i] = 0;
      exp_valid = 1'b0;
      exp_tag   = '0;
      exp_data  = '0;
      exp_flags = '0;
    end else begin
      for (int i = 0; i < N; i++) w[i] = (req[i] && i != g) ? w[i] + 1 : 0;
      if (g >= 0) begin
        exp_valid = 1'b1;
        exp_tag   = r_tag[g];
        exp_data  = r_data[g];
        exp_flags = r_flags[g];
      end else begin
        exp_valid = 1'b0;
        exp_flags = '0;
      end
    end
    last_g = g;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      w[i] = 0; r_tag[i] = '0; r_data[i] = '0; r_flags[i] = '0;
    end

    // reset held for two edges, then released with no requests
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("t1_grant", 32'(grant), 32'd0);
    checkOutput("t1_valid", 32'(cdb_valid), 32'd0);
    checkOutput("t1_starved", 32'(starved), 32'd0);
    step();

    // single request from the int unit
    applyStimulus(3, 6'h15, 32'h0040_0010, 4'b0011);
    #1;
    checkOutput("t2_grant", 32'(grant), 32'b1000);
    step();
    req[3] = 1'b0;
    #1;
    checkOutput("t2_valid", 32'(cdb_valid), 32'd1);
    checkOutput("t2_tag", 32'(cdb_tag), 32'h15);
    checkOutput("t2_data", cdb_data, 32'h0040_0010);
    checkOutput("t2_jalr", 32'(cdb_jalr), 32'd1);
    checkOutput("t2_store_pc", 32'(cdb_store_pc), 32'd1);
    checkOutput("t2_branch", 32'(cdb_branch), 32'd0);
    step();
    #1;
    checkOutput("t2_valid_drop", 32'(cdb_valid), 32'd0);
    step();

    // all four request at once: served strictly by index, back to back
    for (int i = 0; i < N; i++) applyStimulus(i, 6'(8'h20 + i), 32'hA000_0000 + i, 4'(i));
    for (int k = 0; k < N; k++) begin
      #1;
      checkOutput("t3_grant", 32'(grant), 32'(1 << k));
      if (k > 0) begin
        checkOutput("t3_valid", 32'(cdb_valid), 32'd1);
        checkOutput("t3_tag", 32'(cdb_tag), 32'(8'h20 + k - 1));
      end
      step();
      req[k] = 1'b0;
    end
    #1;
    checkOutput("t3_valid_last", 32'(cdb_valid), 32'd1);
    checkOutput("t3_tag_last", 32'(cdb_tag), 32'h23);
    step();
    #1;
    checkOutput("t3_valid_end", 32'(cdb_valid), 32'd0);
    step();

    // divider keeps re-requesting; int unit must be promoted after LIMIT cycles
    applyStimulus(0, 6'h01, 32'h0000_1000, 4'b0000);
    applyStimulus(3, 6'h3F, 32'hDEAD_BEEF, 4'b1100);
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c == 3) begin
        checkOutput("t4_grant_starved", 32'(grant), 32'b1000);
        checkOutput("t4_starved3", 32'(starved[3]), 32'd1);
      end else begin
        checkOutput("t4_grant_div", 32'(grant), 32'b0001);
      end
      if (c == 4) checkOutput("t4_age_cleared", 32'(starved[3]), 32'd0);
      step();
      if (last_g == 0) applyStimulus(0, 6'(c + 2), 32'h0000_1000 + c, 4'b0000);
      if (last_g == 3) req[3] = 1'b0;
    end
    req[0] = 1'b0;
    step();
    step();

    // reset lands in the cycle requester 1 is granted
    applyStimulus(1, 6'h11, 32'h1111_1111, 4'b1010);
    applyStimulus(2, 6'h22, 32'h2222_2222, 4'b0001);
    #1;
    checkOutput("t5_grant_pre", 32'(grant), 32'b0010);
    rst = 1'b0;
    #1;
    checkOutput("t5_grant_rst", 32'(grant), 32'd0);
    step();
    rst = 1'b1;
    #1;
    checkOutput("t5_valid_after", 32'(cdb_valid), 32'd0);
    checkOutput("t5_regrant", 32'(grant), 32'b0010);
    step();
    req[1] = 1'b0;
    #1;
    checkOutput("t5_tag", 32'(cdb_tag), 32'h11);
    checkOutput("t5_grant2", 32'(grant), 32'b0100);
    step();
    req[2] = 1'b0;
    step();

    // randomized traffic obeying the hold-until-granted handshake
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_g == i) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else applyStimulus(i, 6'($urandom), $urandom, 4'($urandom));
        end else if (!req[i] && $urandom_range(9, 0) < 4) begin
          applyStimulus(i, 6'($urandom), $urandom, 4'($urandom));
        end
      end
      step();
    end
    req = '0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
